// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift request scheduler: FSM states,
// direction encoding and a set-bit search used by the LOOK target picker.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MAX_FLOORS  = 64;
    localparam int MAX_FLOOR_W = 6;

    typedef struct packed {
        logic                   found;
        logic [MAX_FLOOR_W-1:0] floor;
    } pick_t;

    // Searches strictly above or below 'from'; nearest takes the first hit
    // walking away from 'from', farthest takes the last one.
    function automatic pick_t pick_floor(input logic [MAX_FLOORS-1:0] vec,
                                         input int                    from,
                                         input logic                  above,
                                         input logic                  nearest);
        pick_t pick;
        pick = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (vec[i] && (above ? (i > from) : (i < from))) begin
                if (!pick.found || (above != nearest)) begin
                    pick.found = 1'b1;
                    pick.floor = MAX_FLOOR_W'(i);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lift_target_select.sv
// Combinational LOOK target picker: nearest car/same-direction hall call
// ahead of the car, else the farthest opposite-direction hall call ahead.
module lift_target_select
    import lift_pkg::*;
#(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pend_up,
    input  logic [N_FLOORS-1:0] pend_dn,
    input  logic [N_FLOORS-1:0] pend_car,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                dir_up,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_found,
    output logic                demand_above,
    output logic                demand_below
);

    logic [N_FLOORS-1:0]   pend_all;
    logic [MAX_FLOORS-1:0] primary;
    logic [MAX_FLOORS-1:0] secondary;
    pick_t                 near_pick;
    pick_t                 far_pick;

    assign pend_all = pend_up | pend_dn | pend_car;

    // Demand flags ignore direction so the FSM can pick a direction first.
    always_comb begin
        demand_above = 1'b0;
        demand_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(current_floor)) demand_above = demand_above | pend_all[i];
            if (i < int'(current_floor)) demand_below = demand_below | pend_all[i];
        end
    end

    always_comb begin
        primary      = MAX_FLOORS'(pend_car | (dir_up ? pend_up : pend_dn));
        secondary    = MAX_FLOORS'(dir_up ? pend_dn : pend_up);
        near_pick    = pick_floor(primary, int'(current_floor), dir_up, 1'b1);
        far_pick     = pick_floor(secondary, int'(current_floor), dir_up, 1'b0);
        target_found = near_pick.found | far_pick.found;
        target_floor = near_pick.found ? FLOOR_W'(near_pick.floor)
                                       : FLOOR_W'(far_pick.floor);
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// Per-floor call latching, LOOK-order target issue and door dwell timing
// between the call buttons and the car motion controller.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS     = 8,
    parameter int FLOOR_W      = $clog2(N_FLOORS),
    parameter int DWELL_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] hall_up_calls,
    input  logic [N_FLOORS-1:0] hall_dn_calls,
    input  logic [N_FLOORS-1:0] car_calls,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                arrive,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic                dir_up,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pend_up,
    output logic [N_FLOORS-1:0] pend_dn,
    output logic [N_FLOORS-1:0] pend_car
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    state_t              state;
    state_t              state_next;
    logic                dir_next;
    logic [N_FLOORS-1:0] up_in;
    logic [N_FLOORS-1:0] dn_in;
    logic [N_FLOORS-1:0] clr_up;
    logic [N_FLOORS-1:0] clr_dn;
    logic [N_FLOORS-1:0] clr_car;
    logic [FLOOR_W-1:0]  sel_target;
    logic                sel_found;
    logic                demand_above;
    logic                demand_below;
    logic                demand_ahead;
    logic                demand_behind;
    logic                here_any;
    logic                at_target;
    logic                serve_arrive;
    logic                dwell_restart;
    logic                dwell_done;
    logic                load_target;
    logic [CNT_W-1:0]    dwell_cnt;

    assign up_in         = hall_up_calls & UP_MASK;
    assign dn_in         = hall_dn_calls & DN_MASK;
    assign here_any      = pend_up[current_floor] | pend_dn[current_floor] | pend_car[current_floor];
    assign at_target     = (current_floor == target_floor);
    assign serve_arrive  = (state == MOVE) && arrive && at_target;
    assign demand_ahead  = dir_up ? demand_above : demand_below;
    assign demand_behind = dir_up ? demand_below : demand_above;
    assign dwell_restart = (state == DOOR) &&
                           (car_calls[current_floor] |
                            (dir_up ? up_in[current_floor] : dn_in[current_floor]));
    assign dwell_done    = (state == DOOR) && !dwell_restart &&
                           (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));

    // The picker looks in the direction the car will have next cycle, so a
    // fresh departure already carries the correct target.
    lift_target_select #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_select (
        .pend_up       (pend_up),
        .pend_dn       (pend_dn),
        .pend_car      (pend_car),
        .current_floor (current_floor),
        .dir_up        (dir_next),
        .target_floor  (sel_target),
        .target_found  (sel_found),
        .demand_above  (demand_above),
        .demand_below  (demand_below)
    );

    always_comb begin
        state_next = state;
        dir_next   = dir_up;
        clr_up     = '0;
        clr_dn     = '0;
        clr_car    = '0;
        case (state)
            IDLE: begin
                if (here_any) begin
                    state_next              = DOOR;
                    clr_car[current_floor]  = 1'b1;
                    clr_up[current_floor]   = 1'b1;
                    clr_dn[current_floor]   = 1'b1;
                end else if (demand_above) begin
                    dir_next   = DIR_UP;
                    state_next = MOVE;
                end else if (demand_below) begin
                    dir_next   = DIR_DN;
                    state_next = MOVE;
                end
            end
            MOVE: begin
                if (serve_arrive) begin
                    state_next             = DOOR;
                    clr_car[current_floor] = 1'b1;
                    if (dir_up) clr_up[current_floor] = 1'b1;
                    else        clr_dn[current_floor] = 1'b1;
                    if (!demand_ahead) begin
                        clr_up[current_floor] = 1'b1;
                        clr_dn[current_floor] = 1'b1;
                        dir_next              = !dir_up;
                    end
                end
            end
            DOOR: begin
                clr_car[current_floor] = 1'b1;
                if (dir_up) clr_up[current_floor] = 1'b1;
                else        clr_dn[current_floor] = 1'b1;
                if (dwell_done) begin
                    if (demand_ahead) begin
                        state_next = MOVE;
                    end else if (demand_behind) begin
                        dir_next   = !dir_up;
                        state_next = MOVE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold the target once the car reaches it so the pending arrive still
    // matches; the strictly-beyond search would otherwise skip ahead.
    assign load_target = (state_next == MOVE) && sel_found &&
                         !((state == MOVE) && at_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_up       <= DIR_UP;
            pend_up      <= '0;
            pend_dn      <= '0;
            pend_car     <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            door_open    <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            dir_up       <= dir_next;
            pend_up      <= (pend_up | up_in) & ~clr_up;
            pend_dn      <= (pend_dn | dn_in) & ~clr_dn;
            pend_car     <= (pend_car | car_calls) & ~clr_car;
            target_valid <= (state_next == MOVE);
            door_open    <= (state_next == DOOR);
            if (load_target) begin
                target_floor <= sel_target;
            end
            if ((state == DOOR) && (state_next == DOOR) && !dwell_restart) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Scenario bench for lift_request_scheduler with an expected-target queue
// filled at stimulus time and drained as the scheduler issues targets.
module tb_lift_request_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] hall_up_calls;
    logic [7:0] hall_dn_calls;
    logic [7:0] car_calls;
    logic [2:0] current_floor;
    logic       arrive;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       dir_up;
    logic       door_open;
    logic [7:0] pend_up;
    logic [7:0] pend_dn;
    logic [7:0] pend_car;

    int checks = 0;
    int passed = 0;
    int exp_q[$];

    lift_request_scheduler #(
        .N_FLOORS     (8),
        .FLOOR_W      (3),
        .DWELL_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hall_up_calls (hall_up_calls),
        .hall_dn_calls (hall_dn_calls),
        .car_calls     (car_calls),
        .current_floor (current_floor),
        .arrive        (arrive),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .pend_up       (pend_up),
        .pend_dn       (pend_dn),
        .pend_car      (pend_car)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] floor);
        rst_n         = 1'b0;
        hall_up_calls = '0;
        hall_dn_calls = '0;
        car_calls     = '0;
        arrive        = 1'b0;
        current_floor = floor;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_target(output bit ok);
        int n;
        n = 0;
        while (!target_valid && n < 60) begin
            tick();
            n++;
        end
        ok = target_valid;
    endtask

    task automatic wait_door_close(output int cycles);
        cycles = 0;
        while (door_open && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic arrive_at(input logic [2:0] floor);
        current_floor = floor;
        arrive        = 1'b1;
        tick();
        arrive = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd0);
        checks++;
        if (target_valid !== 1'b0) $display("[TB] FAIL reset_target_valid: got %b expected 0", target_valid);
        else passed++;
        checks++;
        if (target_floor !== 3'd0) $display("[TB] FAIL reset_target_floor: got %0d expected 0", target_floor);
        else passed++;
        checks++;
        if (dir_up !== 1'b1) $display("[TB] FAIL reset_dir_up: got %b expected 1", dir_up);
        else passed++;
        checks++;
        if (door_open !== 1'b0) $display("[TB] FAIL reset_door_open: got %b expected 0", door_open);
        else passed++;
        checks++;
        if ({pend_up, pend_dn, pend_car} !== 24'h0) $display("[TB] FAIL reset_pend: got %h expected 000000", {pend_up, pend_dn, pend_car});
        else passed++;
    endtask

    task automatic test_single_call();
        int exp;
        int n;
        do_reset(3'd0);
        car_calls = 8'b0010_0000;
        exp_q.push_back(5);
        tick();
        car_calls = '0;
        checks++;
        if (pend_car !== 8'b0010_0000 || target_valid !== 1'b0)
            $display("[TB] FAIL single_cycle1: got pend_car=%b tv=%b expected 00100000 tv=0", pend_car, target_valid);
        else passed++;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 3'(exp) || dir_up !== 1'b1)
            $display("[TB] FAIL single_cycle2: got tv=%b tf=%0d up=%b expected tv=1 tf=%0d up=1", target_valid, target_floor, dir_up, exp);
        else passed++;
        arrive_at(3'd5);
        checks++;
        if (door_open !== 1'b1 || pend_car !== 8'h00)
            $display("[TB] FAIL single_arrive: got door=%b pend_car=%b expected door=1 pend_car=00000000", door_open, pend_car);
        else passed++;
        wait_door_close(n);
        checks++;
        if (n !== 4) $display("[TB] FAIL single_dwell: got %0d cycles expected 4", n);
        else passed++;
        tick();
        checks++;
        if (target_valid !== 1'b0 || door_open !== 1'b0)
            $display("[TB] FAIL single_idle: got tv=%b door=%b expected 0 0", target_valid, door_open);
        else passed++;
    endtask

    task automatic test_retarget();
        int exp;
        int n;
        do_reset(3'd0);
        car_calls = 8'b0100_0000;
        exp_q.push_back(6);
        tick();
        car_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 3'(exp))
            $display("[TB] FAIL retarget_initial: got tv=%b tf=%0d expected tv=1 tf=%0d", target_valid, target_floor, exp);
        else passed++;
        current_floor = 3'd1;
        hall_up_calls = 8'b0000_1000;
        exp_q.push_back(3);
        tick();
        hall_up_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_floor !== 3'(exp)) $display("[TB] FAIL retarget_nearer: got %0d expected %0d", target_floor, exp);
        else passed++;
        arrive_at(3'd3);
        checks++;
        if (dir_up !== 1'b1 || pend_up !== 8'h00 || pend_car !== 8'b0100_0000)
            $display("[TB] FAIL retarget_serve3: got up=%b pend_up=%b pend_car=%b expected up=1 00000000 01000000", dir_up, pend_up, pend_car);
        else passed++;
        exp_q.push_back(6);
        wait_door_close(n);
        exp = exp_q.pop_front();
        checks++;
        if (n !== 4 || target_valid !== 1'b1 || target_floor !== 3'(exp))
            $display("[TB] FAIL retarget_resume: got dwell=%0d tv=%b tf=%0d expected dwell=4 tv=1 tf=%0d", n, target_valid, target_floor, exp);
        else passed++;
        arrive_at(3'd6);
        wait_door_close(n);
    endtask

    task automatic test_opposite_hall();
        int exp;
        int n;
        bit ok;
        do_reset(3'd0);
        car_calls     = 8'b0000_0100;
        hall_dn_calls = 8'b0010_0000;
        exp_q.push_back(2);
        tick();
        car_calls     = '0;
        hall_dn_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 3'(exp))
            $display("[TB] FAIL opp_first: got tv=%b tf=%0d expected tv=1 tf=%0d", target_valid, target_floor, exp);
        else passed++;
        arrive_at(3'd2);
        checks++;
        if (dir_up !== 1'b1 || pend_dn !== 8'b0010_0000)
            $display("[TB] FAIL opp_at2: got up=%b pend_dn=%b expected up=1 00100000", dir_up, pend_dn);
        else passed++;
        exp_q.push_back(5);
        wait_door_close(n);
        wait_target(ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || target_floor !== 3'(exp))
            $display("[TB] FAIL opp_target: got tv=%b tf=%0d expected tv=1 tf=%0d", ok, target_floor, exp);
        else passed++;
        arrive_at(3'd5);
        checks++;
        if (dir_up !== 1'b0 || pend_dn !== 8'h00)
            $display("[TB] FAIL opp_flip: got up=%b pend_dn=%b expected up=0 00000000", dir_up, pend_dn);
        else passed++;
        wait_door_close(n);
    endtask

    task automatic test_door_restart();
        int exp;
        int n;
        do_reset(3'd0);
        car_calls = 8'b1001_0000;
        exp_q.push_back(4);
        tick();
        car_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_floor !== 3'(exp)) $display("[TB] FAIL restart_target: got %0d expected %0d", target_floor, exp);
        else passed++;
        arrive_at(3'd4);
        checks++;
        if (door_open !== 1'b1 || dir_up !== 1'b1)
            $display("[TB] FAIL restart_door: got door=%b up=%b expected 1 1", door_open, dir_up);
        else passed++;
        tick();
        car_calls = 8'b0001_0000;
        tick();
        car_calls = '0;
        checks++;
        if (pend_car !== 8'b1000_0000) $display("[TB] FAIL restart_no_latch: got %b expected 10000000", pend_car);
        else passed++;
        wait_door_close(n);
        checks++;
        if (n !== 4) $display("[TB] FAIL restart_dwell: got %0d cycles expected 4", n);
        else passed++;
        exp_q.push_back(7);
        exp = exp_q.pop_front();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 3'(exp))
            $display("[TB] FAIL restart_next: got tv=%b tf=%0d expected tv=1 tf=%0d", target_valid, target_floor, exp);
        else passed++;
        arrive_at(3'd7);
        wait_door_close(n);
    endtask

    task automatic test_stray_arrive();
        int exp;
        int n;
        do_reset(3'd0);
        arrive_at(3'd0);
        checks++;
        if (door_open !== 1'b0 || target_valid !== 1'b0)
            $display("[TB] FAIL stray_idle: got door=%b tv=%b expected 0 0", door_open, target_valid);
        else passed++;
        car_calls = 8'b0010_0000;
        exp_q.push_back(5);
        tick();
        car_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_floor !== 3'(exp)) $display("[TB] FAIL stray_target: got %0d expected %0d", target_floor, exp);
        else passed++;
        arrive_at(3'd3);
        checks++;
        if (door_open !== 1'b0 || target_valid !== 1'b1 || target_floor !== 3'd5 || pend_car !== 8'b0010_0000)
            $display("[TB] FAIL stray_mismatch: got door=%b tv=%b tf=%0d pend_car=%b expected 0 1 5 00100000",
                     door_open, target_valid, target_floor, pend_car);
        else passed++;
        arrive_at(3'd5);
        wait_door_close(n);
    endtask

    task automatic test_reset_mid_dwell();
        int exp;
        int n;
        do_reset(3'd3);
        car_calls = 8'b0100_1010;
        tick();
        car_calls = '0;
        tick();
        checks++;
        if (door_open !== 1'b1 || pend_car !== 8'b0100_0010)
            $display("[TB] FAIL middwell_setup: got door=%b pend_car=%b expected 1 01000010", door_open, pend_car);
        else passed++;
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (door_open !== 1'b0 || target_valid !== 1'b0 || target_floor !== 3'd0 || dir_up !== 1'b1 ||
            {pend_up, pend_dn, pend_car} !== 24'h0)
            $display("[TB] FAIL middwell_async: got door=%b tv=%b tf=%0d up=%b pend=%h expected 0 0 0 1 000000",
                     door_open, target_valid, target_floor, dir_up, {pend_up, pend_dn, pend_car});
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (target_valid !== 1'b0 || door_open !== 1'b0)
            $display("[TB] FAIL middwell_quiet: got tv=%b door=%b expected 0 0", target_valid, door_open);
        else passed++;
        car_calls = 8'b0010_0000;
        exp_q.push_back(5);
        tick();
        car_calls = '0;
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (target_valid !== 1'b1 || target_floor !== 3'(exp))
            $display("[TB] FAIL middwell_newcall: got tv=%b tf=%0d expected tv=1 tf=%0d", target_valid, target_floor, exp);
        else passed++;
        arrive_at(3'd5);
        wait_door_close(n);
    endtask

    task automatic test_back_to_back();
        int exp;
        int n;
        bit ok;
        int order[12] = '{4, 5, 6, 7, 6, 5, 4, 2, 1, 0, 1, 2};
        do_reset(3'd3);
        foreach (order[i]) exp_q.push_back(order[i]);
        hall_up_calls = 8'hFF;
        hall_dn_calls = 8'hFF;
        car_calls     = 8'hFF;
        tick();
        hall_up_calls = '0;
        hall_dn_calls = '0;
        car_calls     = '0;
        tick();
        checks++;
        if (door_open !== 1'b1 || pend_car !== 8'b1111_0111 || pend_up !== 8'b0111_0111 || pend_dn !== 8'b1111_0110)
            $display("[TB] FAIL sweep_latch: got door=%b car=%b up=%b dn=%b expected 1 11110111 01110111 11110110",
                     door_open, pend_car, pend_up, pend_dn);
        else passed++;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            wait_target(ok);
            checks++;
            if (!ok || target_floor !== 3'(exp))
                $display("[TB] FAIL sweep_order: got tv=%b tf=%0d expected tv=1 tf=%0d", ok, target_floor, exp);
            else passed++;
            arrive_at(3'(exp));
        end
        wait_door_close(n);
        tick();
        checks++;
        if (target_valid !== 1'b0 || {pend_up, pend_dn, pend_car} !== 24'h0)
            $display("[TB] FAIL sweep_drained: got tv=%b pend=%h expected 0 000000", target_valid, {pend_up, pend_dn, pend_car});
        else passed++;
    endtask

    initial begin
        rst_n         = 1'b0;
        hall_up_calls = '0;
        hall_dn_calls = '0;
        car_calls     = '0;
        current_floor = '0;
        arrive        = 1'b0;
        $display("[TB] lift_request_scheduler bench start");
        test_reset();
        test_single_call();
        test_retarget();
        test_opposite_hall();
        test_door_restart();
        test_stray_arrive();
        test_reset_mid_dwell();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
